// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Responder end of the per-thread LSU memory interface. Collects read and
//   write requests from NUM_CONSUMERS LSU ports and forwards them to
//   NUM_CHANNELS external memory channels. Each channel is granted
//   round-robin across consumers.
//
// Handshake (identical on both sides, 4-phase):
//   requester raises valid with address/data -> responder eventually raises
//   ready (with read data) -> requester drops valid -> responder drops ready.
//   Address/data are sampled once at grant; later changes are ignored.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   consumer_read_*            per-consumer read request / ready / data
//   consumer_write_*           per-consumer write request / ready
//   mem_read_*                 per-channel read request to memory
//   mem_write_*                per-channel write request to memory
//   debug_channel_state        3 bits of FSM state per channel (ch0 in LSBs)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CONSUMERS-1:0]  consumer_read_valid,
  input  logic [ADDR_BITS-1:0]      consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]  consumer_read_ready,
  output logic [DATA_BITS-1:0]      consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]  consumer_write_valid,
  input  logic [ADDR_BITS-1:0]      consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]      consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]  consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]   mem_read_valid,
  output logic [ADDR_BITS-1:0]      mem_read_address       [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]   mem_read_ready,
  input  logic [DATA_BITS-1:0]      mem_read_data          [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]   mem_write_valid,
  output logic [ADDR_BITS-1:0]      mem_write_address      [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]      mem_write_data         [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]   mem_write_ready,
  output logic [3*NUM_CHANNELS-1:0] debug_channel_state
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] READ_WAITING   = 3'd1;
  localparam logic [2:0] WRITE_WAITING  = 3'd2;
  localparam logic [2:0] READ_RELAYING  = 3'd3;
  localparam logic [2:0] WRITE_RELAYING = 3'd4;

  logic [2:0]               r_state   [NUM_CHANNELS];
  logic [CW-1:0]            r_owner   [NUM_CHANNELS];
  logic [CW-1:0]            r_rr_ptr  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_claimed;

  logic [NUM_CHANNELS-1:0]  r_mem_read_valid;
  logic [ADDR_BITS-1:0]     r_mem_read_address  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  r_mem_write_valid;
  logic [ADDR_BITS-1:0]     r_mem_write_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     r_mem_write_data    [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_cons_read_ready;
  logic [DATA_BITS-1:0]     r_cons_read_data    [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] r_cons_write_ready;

  // Grant decisions for channels currently IDLE.
  logic [NUM_CONSUMERS-1:0] w_taken;
  logic [NUM_CHANNELS-1:0]  w_grant;
  logic [NUM_CHANNELS-1:0]  w_grant_read;
  logic [CW-1:0]            w_grant_idx [NUM_CHANNELS];

  // Channels resolve in ascending order; w_taken accumulates consumers that
  // are already claimed or were just picked by a lower channel, so no
  // consumer can be granted twice in the same cycle.
  always_comb begin : grant_scan
    int            idx;
    logic [CW-1:0] cidx;
    idx          = 0;
    cidx         = '0;
    w_taken      = r_claimed;
    w_grant      = '0;
    w_grant_read = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_grant_idx[ch] = '0;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (r_state[ch] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = int'(r_rr_ptr[ch]) + k;
          if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
          cidx = CW'(idx);
          if (!w_grant[ch] && !w_taken[cidx] &&
              (consumer_read_valid[cidx] || consumer_write_valid[cidx])) begin
            w_grant[ch]      = 1'b1;
            w_grant_idx[ch]  = cidx;
            // Read wins when a consumer presents both.
            w_grant_read[ch] = consumer_read_valid[cidx];
          end
        end
        if (w_grant[ch]) w_taken[w_grant_idx[ch]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_claimed          <= '0;
      r_mem_read_valid   <= '0;
      r_mem_write_valid  <= '0;
      r_cons_read_ready  <= '0;
      r_cons_write_ready <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch]             <= IDLE;
        r_owner[ch]             <= '0;
        r_rr_ptr[ch]            <= '0;
        r_mem_read_address[ch]  <= '0;
        r_mem_write_address[ch] <= '0;
        r_mem_write_data[ch]    <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        r_cons_read_data[c] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (r_state[ch])
          IDLE: begin
            if (w_grant[ch]) begin
              r_claimed[w_grant_idx[ch]] <= 1'b1;
              r_owner[ch]                <= w_grant_idx[ch];
              r_rr_ptr[ch] <= (w_grant_idx[ch] == CW'(NUM_CONSUMERS - 1)) ?
                              '0 : w_grant_idx[ch] + 1'b1;
              if (w_grant_read[ch]) begin
                r_mem_read_valid[ch]   <= 1'b1;
                r_mem_read_address[ch] <= consumer_read_address[w_grant_idx[ch]];
                r_state[ch]            <= READ_WAITING;
              end else begin
                r_mem_write_valid[ch]   <= 1'b1;
                r_mem_write_address[ch] <= consumer_write_address[w_grant_idx[ch]];
                r_mem_write_data[ch]    <= consumer_write_data[w_grant_idx[ch]];
                r_state[ch]             <= WRITE_WAITING;
              end
            end
          end
          READ_WAITING: begin
            if (mem_read_ready[ch]) begin
              r_mem_read_valid[ch]              <= 1'b0;
              r_cons_read_data[r_owner[ch]]     <= mem_read_data[ch];
              r_cons_read_ready[r_owner[ch]]    <= 1'b1;
              r_state[ch]                       <= READ_RELAYING;
            end
          end
          WRITE_WAITING: begin
            if (mem_write_ready[ch]) begin
              r_mem_write_valid[ch]           <= 1'b0;
              r_cons_write_ready[r_owner[ch]] <= 1'b1;
              r_state[ch]                     <= WRITE_RELAYING;
            end
          end
          READ_RELAYING: begin
            if (!consumer_read_valid[r_owner[ch]]) begin
              r_cons_read_ready[r_owner[ch]] <= 1'b0;
              r_claimed[r_owner[ch]]         <= 1'b0;
              r_state[ch]                    <= IDLE;
            end
          end
          WRITE_RELAYING: begin
            if (!consumer_write_valid[r_owner[ch]]) begin
              r_cons_write_ready[r_owner[ch]] <= 1'b0;
              r_claimed[r_owner[ch]]          <= 1'b0;
              r_state[ch]                     <= IDLE;
            end
          end
          default: r_state[ch] <= IDLE;
        endcase
      end
    end
  end

  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign consumer_read_ready  = r_cons_read_ready;
  assign consumer_read_data   = r_cons_read_data;
  assign consumer_write_ready = r_cons_write_ready;

  always_comb begin
    debug_channel_state = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      debug_channel_state[ch*3 +: 3] = r_state[ch];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. Instance u_dut uses one channel,
//   instance u_dut2 uses two channels for the concurrent-grant case.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- single-channel DUT signals ----------------
  logic [3:0] crv, crr, cwv, cwr;
  logic [7:0] cra [4];
  logic [7:0] crd [4];
  logic [7:0] cwa [4];
  logic [7:0] cwd [4];
  logic [0:0] mrv, mrr, mwv, mwr;
  logic [7:0] mra [1];
  logic [7:0] mrd [1];
  logic [7:0] mwa [1];
  logic [7:0] mwd [1];
  logic [2:0] dbg;

  // ---------------- two-channel DUT signals ----------------
  logic [3:0] b_crv, b_crr, b_cwv, b_cwr;
  logic [7:0] b_cra [4];
  logic [7:0] b_crd [4];
  logic [7:0] b_cwa [4];
  logic [7:0] b_cwd [4];
  logic [1:0] b_mrv, b_mrr, b_mwv, b_mwr;
  logic [7:0] b_mra [2];
  logic [7:0] b_mrd [2];
  logic [7:0] b_mwa [2];
  logic [7:0] b_mwd [2];
  logic [5:0] b_dbg;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr),
    .debug_channel_state(dbg)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
    .debug_channel_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    crv = '0; cwv = '0; mrr = '0; mwr = '0;
    b_crv = '0; b_cwv = '0; b_mrr = '0; b_mwr = '0;
    for (int i = 0; i < 4; i++) begin
      cra[i] = '0; cwa[i] = '0; cwd[i] = '0;
      b_cra[i] = '0; b_cwa[i] = '0; b_cwd[i] = '0;
    end
    mrd[0] = '0;
    b_mrd[0] = '0; b_mrd[1] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         rdy_cnt [4];
    int         served;
    logic [3:0] prev;
    logic [7:0] e;

    clear_inputs();
    do_reset();

    // Reset state
    check("rst_mrv", mrv, 0);
    check("rst_mwv", mwv, 0);
    check("rst_crr", crr, 0);
    check("rst_cwr", cwr, 0);
    check("rst_dbg", dbg, 0);
    check("rst_b_mrv", b_mrv, 0);

    // Test 1: consumer 2 reads 0x10, memory answers 0xAB after 3 cycles
    crv[2] = 1'b1; cra[2] = 8'h10;
    #1 check("t1_pre_mrv", mrv, 0);
    step();
    check("t1_mrv", mrv, 1);
    check("t1_mra", mra[0], 8'h10);
    check("t1_dbg_rw", dbg, 3'd1);
    cra[2] = 8'h99;                       // must be ignored while claimed
    step();
    check("t1_hold_mra", mra[0], 8'h10);
    step();
    check("t1_hold_mrv", mrv, 1);
    check("t1_crr_wait", crr, 0);
    mrr[0] = 1'b1; mrd[0] = 8'hAB;
    step();
    check("t1_crr", crr, 4'b0100);
    check("t1_crd", crd[2], 8'hAB);
    check("t1_mrv_drop", mrv, 0);
    check("t1_dbg_rr", dbg, 3'd3);
    mrr[0] = 1'b0;
    step();
    check("t1_crr_held", crr, 4'b0100);
    crv[2] = 1'b0;
    step();
    check("t1_crr_drop", crr, 0);
    check("t1_mwv_never", mwv, 0);
    check("t1_dbg_idle", dbg, 3'd0);

    // Test 2: consumer 1 writes 0x55 to 0x20
    cwv[1] = 1'b1; cwa[1] = 8'h20; cwd[1] = 8'h55;
    step();
    check("t2_mwv", mwv, 1);
    check("t2_mwa", mwa[0], 8'h20);
    check("t2_mwd", mwd[0], 8'h55);
    check("t2_mrv", mrv, 0);
    mwr[0] = 1'b1;
    step();
    check("t2_cwr", cwr, 4'b0010);
    check("t2_crr", crr, 0);
    check("t2_mwv_drop", mwv, 0);
    mwr[0] = 1'b0; cwv[1] = 1'b0;
    step();
    check("t2_cwr_drop", cwr, 0);

    // Test 3: all four consumers read at once; order must be 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cra[i] = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
      rdy_cnt[i] = 0;
    end
    crv = 4'hF;
    prev = '0;
    served = 0;
    for (int cyc = 0; cyc < 60 && served < 4; cyc++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (crr[i] && !prev[i]) begin
          rdy_cnt[i]++;
          served++;
          e = (8'h30 + 8'(i)) ^ 8'hFF;
          check("t3_data", crd[i], e);
          crv[i] = 1'b0;
        end
      end
      prev = crr;
      if (mrv[0] && !mrr[0]) begin
        if (exp_q.size() == 0) check("t3_extra_grant", mra[0], 0);
        else                   check("t3_order", mra[0], exp_q.pop_front());
        mrd[0] = mra[0] ^ 8'hFF;
        mrr[0] = 1'b1;
      end else begin
        mrr[0] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) check("t3_once", rdy_cnt[i], 1);
    check("t3_all_granted", exp_q.size(), 0);
    clear_inputs();
    step();
    step();

    // Test 4: two channels, consumers 0 and 3 request together
    b_crv = 4'b1001; b_cra[0] = 8'h40; b_cra[3] = 8'h43;
    step();
    check("t4_mrv", b_mrv, 2'b11);
    check("t4_mra0", b_mra[0], 8'h40);
    check("t4_mra1", b_mra[1], 8'h43);
    check("t4_dbg", b_dbg, {3'd1, 3'd1});
    b_mrr = 2'b11; b_mrd[0] = 8'h11; b_mrd[1] = 8'h33;
    step();
    check("t4_crr", b_crr, 4'b1001);
    check("t4_crd0", b_crd[0], 8'h11);
    check("t4_crd3", b_crd[3], 8'h33);
    b_mrr = '0; b_crv = '0;
    step();
    check("t4_crr_drop", b_crr, 0);
    step();
    check("t4_no_regrant", b_mrv, 0);

    // Test 5: reset while READ_WAITING, then a fresh request
    crv[0] = 1'b1; cra[0] = 8'h50;
    step();
    check("t5_mrv", mrv, 1);
    step();
    reset = 1'b1;
    step();
    check("t5_rst_mrv", mrv, 0);
    check("t5_rst_crr", crr, 0);
    check("t5_rst_dbg", dbg, 0);
    reset = 1'b0;
    cra[0] = 8'h51;
    step();
    check("t5_fresh_mrv", mrv, 1);
    check("t5_fresh_mra", mra[0], 8'h51);
    mrr[0] = 1'b1; mrd[0] = 8'h77;
    step();
    check("t5_crr", crr, 4'b0001);
    check("t5_crd", crd[0], 8'h77);
    mrr[0] = 1'b0; crv[0] = 1'b0;
    step();
    check("t5_crr_drop", crr, 0);

    // Test 6: spurious memory ready while idle, then a long valid hold
    mrr[0] = 1'b1; mrd[0] = 8'hEE;
    step();
    check("t6_spur_crr", crr, 0);
    check("t6_spur_mrv", mrv, 0);
    check("t6_spur_crd", crd[0], 8'h77);
    mrr[0] = 1'b0;
    crv[3] = 1'b1; cra[3] = 8'h60;
    step();
    check("t6_mra", mra[0], 8'h60);
    mrr[0] = 1'b1; mrd[0] = 8'h66;
    step();
    check("t6_crd", crd[3], 8'h66);
    mrr[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t6_hold", crr, 4'b1000);
      step();
    end
    check("t6_hold_last", crr, 4'b1000);
    crv[3] = 1'b0;
    step();
    check("t6_drop", crr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
